// File: rtl/inst_buffer.sv
// inst_buffer: circular instruction FIFO between predecode and decode.
// Accepts up to ICACHE_BANK instructions per cycle from predecode and
// presents up to FETCH_WIDTH of the oldest instructions to decode.
// When there is not enough room for a full predecode group, it raises
// ib_stall so that predecode holds its data.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   pd_en      per-slot valid from predecode (thermometer from bit 0)
//   pd_num     valid count minus 1 (ignored when pd_en == 0)
//   pd_inst    predecode instructions, slot 0 oldest
//   flush      backend redirect; empties the buffer on the next edge
//   dec_stall  decode cannot accept this cycle
//   ib_stall   enqueue will not be accepted this cycle
//   dec_en     per-slot valid to decode (thermometer from bit 0)
//   dec_inst   instructions to decode, slot 0 oldest
module inst_buffer #(
  parameter int unsigned ICACHE_BANK = 4,
  parameter int unsigned FETCH_WIDTH = 4,
  parameter int unsigned DEPTH       = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [ICACHE_BANK-1:0]              pd_en,
  input  logic [$clog2(ICACHE_BANK)-1:0]      pd_num,
  input  logic [ICACHE_BANK-1:0][31:0]        pd_inst,
  input  logic                                flush,
  input  logic                                dec_stall,
  output logic                                ib_stall,
  output logic [FETCH_WIDTH-1:0]              dec_en,
  output logic [FETCH_WIDTH-1:0][31:0]        dec_inst
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  // Pointers carry an extra wrap bit so that full (DEPTH) and empty (0)
  // are distinguishable through count = tail - head.
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] count;
  logic [PW-1:0] free_n;
  logic [PW-1:0] enq_n;
  logic [PW-1:0] deq_n;
  logic          enq_fire;
  logic          deq_fire;

  logic [31:0] mem [DEPTH];

  assign count  = tail - head;
  assign free_n = PW'(DEPTH) - count;

  // Full check is on the registered occupancy only; a same-cycle dequeue
  // does not make room for this cycle's enqueue.
  assign ib_stall = free_n < PW'(ICACHE_BANK);

  assign enq_n    = PW'(pd_num) + PW'(1);
  assign deq_n    = (count < PW'(FETCH_WIDTH)) ? count : PW'(FETCH_WIDTH);
  assign enq_fire = (|pd_en) && !ib_stall && !flush;
  assign deq_fire = !dec_stall && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (enq_fire) tail <= tail + enq_n;
      if (deq_fire) head <= head + deq_n;
    end
  end

  // Entry storage is not reset; only slots below enq_n are written.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      for (int unsigned i = 0; i < ICACHE_BANK; i++) begin
        if (PW'(i) < enq_n) mem[tail[AW-1:0] + AW'(i)] <= pd_inst[i];
      end
    end
  end

  always_comb begin
    dec_en   = '0;
    dec_inst = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      dec_en[i]   = PW'(i) < count;
      dec_inst[i] = mem[head[AW-1:0] + AW'(i)];
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer. A queue-based reference model holds
// the expected instruction stream: accepted enqueues are pushed, dequeues
// pop the oldest entries, and the DUT's decode view is compared against it.
module tb_inst_buffer;

  localparam int IB = 4;
  localparam int FW = 4;
  localparam int D  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [IB-1:0]     pd_en;
  logic [1:0]        pd_num;
  logic [IB-1:0][31:0] pd_inst;
  logic              flush;
  logic              dec_stall;
  logic              ib_stall;
  logic [FW-1:0]     dec_en;
  logic [FW-1:0][31:0] dec_inst;

  int nerr = 0;
  int nchk = 0;

  logic [31:0] sb[$];
  logic [4:0]  m_head;
  logic [4:0]  m_tail;

  inst_buffer #(.ICACHE_BANK(IB), .FETCH_WIDTH(FW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .pd_en(pd_en), .pd_num(pd_num), .pd_inst(pd_inst),
    .flush(flush), .dec_stall(dec_stall), .ib_stall(ib_stall),
    .dec_en(dec_en), .dec_inst(dec_inst)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst && pd_en != 4'd0)
      assert ((((pd_en + 4'd1) & pd_en) == 4'd0) && ($countones(pd_en) == int'(pd_num) + 1))
        else $error("illegal predecode input en=%b num=%0d", pd_en, pd_num);
  end

  // Drives one cycle of stimulus from a negedge, updates the model at the
  // posedge, and returns at the following negedge.
  task automatic cycle(input int n, input logic [31:0] base, input bit fl, input bit st);
    bit stall_m;
    bit enq;
    int dn;
    for (int i = 0; i < IB; i++) pd_inst[i] = base + 32'(i);
    pd_en     = 4'((1 << n) - 1);
    pd_num    = (n > 0) ? 2'(n - 1) : 2'd0;
    flush     = fl;
    dec_stall = st;
    @(posedge clk);
    stall_m = (D - sb.size()) < IB;
    enq     = (n > 0) && !stall_m && !fl;
    dn      = (st || fl) ? 0 : ((sb.size() < FW) ? sb.size() : FW);
    if (fl) begin
      sb.delete();
      m_head = '0;
      m_tail = '0;
    end else begin
      if (enq) begin
        for (int i = 0; i < n; i++) sb.push_back(base + 32'(i));
        m_tail = m_tail + 5'(n);
      end
      for (int j = 0; j < dn; j++) void'(sb.pop_front());
      m_head = m_head + 5'(dn);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; pd_en = '0; pd_num = '0; pd_inst = '0; flush = 1'b0; dec_stall = 1'b0;
    sb.delete(); m_head = '0; m_tail = '0;
    #1;
    nchk++; if (dec_en !== 4'b0000) begin nerr++; $display("FAIL reset_dec_en got %b exp 0000", dec_en); end
    nchk++; if (ib_stall !== 1'b0) begin nerr++; $display("FAIL reset_ib_stall got %b exp 0", ib_stall); end
    @(negedge clk);
    rst = 1'b1;
    cycle(4, 32'h1000_0000, 0, 1);
    cycle(3, 32'h1100_0000, 0, 1);
    nchk++; if (dut.count !== 5'd7) begin nerr++; $display("FAIL pre_reset_count got %0d exp 7", dut.count); end
    #2 rst = 1'b0;
    #1;
    nchk++; if (dec_en !== 4'b0000) begin nerr++; $display("FAIL async_reset_dec_en got %b exp 0000", dec_en); end
    nchk++; if (ib_stall !== 1'b0) begin nerr++; $display("FAIL async_reset_ib_stall got %b exp 0", ib_stall); end
    nchk++; if (dut.count !== 5'd0) begin nerr++; $display("FAIL async_reset_count got %0d exp 0", dut.count); end
    sb.delete(); m_head = '0; m_tail = '0;
    @(negedge clk);
    rst = 1'b1;
    cycle(1, 32'hC0DE_0000, 0, 1);
    nchk++; if (dut.mem[0] !== 32'hC0DE_0000) begin nerr++; $display("FAIL post_reset_entry0 got %h exp c0de0000", dut.mem[0]); end
    nchk++; if (dec_en !== 4'b0001) begin nerr++; $display("FAIL post_reset_dec_en got %b exp 0001", dec_en); end
    nchk++; if (dec_inst[0] !== 32'hC0DE_0000) begin nerr++; $display("FAIL post_reset_inst0 got %h exp c0de0000", dec_inst[0]); end
  endtask

  task automatic test_basic();
    cycle(0, 32'h0, 1, 0);
    cycle(3, 32'hA000_0000, 0, 0);
    nchk++; if (dec_en !== 4'b0111) begin nerr++; $display("FAIL basic_dec_en got %b exp 0111", dec_en); end
    for (int i = 0; i < 3; i++) begin
      nchk++;
      if (dec_inst[i] !== 32'hA000_0000 + 32'(i)) begin
        nerr++; $display("FAIL basic_inst%0d got %h exp %h", i, dec_inst[i], 32'hA000_0000 + 32'(i));
      end
    end
    cycle(0, 32'h0, 0, 0);
    nchk++; if (dut.count !== 5'd0) begin nerr++; $display("FAIL basic_drained_count got %0d exp 0", dut.count); end
    nchk++; if (dec_en !== 4'b0000) begin nerr++; $display("FAIL basic_drained_dec_en got %b exp 0000", dec_en); end
  endtask

  task automatic test_fill_stall();
    for (int k = 0; k < 3; k++) cycle(4, 32'hB000_0000 + 32'(k * 16), 0, 1);
    nchk++; if (dut.count !== 5'd12) begin nerr++; $display("FAIL fill12_count got %0d exp 12", dut.count); end
    // 16 - 12 = 4 free entries, exactly one full group: not stalled
    nchk++; if (ib_stall !== 1'b0) begin nerr++; $display("FAIL fill12_ib_stall got %b exp 0", ib_stall); end
    cycle(4, 32'hB000_0030, 0, 1);
    nchk++; if (dut.count !== 5'd16) begin nerr++; $display("FAIL fill16_count got %0d exp 16", dut.count); end
    nchk++; if (ib_stall !== 1'b1) begin nerr++; $display("FAIL fill16_ib_stall got %b exp 1", ib_stall); end
    cycle(4, 32'hDEAD_0000, 0, 1);
    nchk++; if (dut.count !== 5'd16) begin nerr++; $display("FAIL dropped_count got %0d exp 16", dut.count); end
    nchk++; if (dec_en !== 4'b1111) begin nerr++; $display("FAIL stalled_dec_en got %b exp 1111", dec_en); end
    nchk++; if (dec_inst[0] !== 32'hB000_0000) begin nerr++; $display("FAIL stalled_inst0 got %h exp b0000000", dec_inst[0]); end
    nchk++; if (sb.size() != 16) begin nerr++; $display("FAIL model_dropped got %0d exp 16", sb.size()); end
    for (int k = 0; k < 4; k++) cycle(0, 32'h0, 0, 0);
    nchk++; if (dut.count !== 5'd0) begin nerr++; $display("FAIL fill_drain_count got %0d exp 0", dut.count); end
  endtask

  task automatic test_wrap();
    cycle(0, 32'h0, 1, 0);
    for (int k = 0; k < 3; k++) cycle(4, 32'h2000_0000 + 32'(k * 16), 0, 1);
    cycle(2, 32'h2000_0030, 0, 1);
    for (int k = 0; k < 4; k++) cycle(0, 32'h0, 0, 0);
    nchk++; if (dut.head !== 5'd14 || dut.tail !== 5'd14) begin
      nerr++; $display("FAIL wrap_start_ptrs got head=%0d tail=%0d exp 14/14", dut.head, dut.tail);
    end
    cycle(4, 32'hE000_0000, 0, 1);
    for (int i = 0; i < 4; i++) begin
      nchk++;
      if (dec_inst[i] !== sb[i]) begin nerr++; $display("FAIL wrap_inst%0d got %h exp %h", i, dec_inst[i], sb[i]); end
    end
    nchk++; if (dut.mem[1] !== 32'hE000_0003) begin nerr++; $display("FAIL wrap_entry1 got %h exp e0000003", dut.mem[1]); end
    nchk++; if (dut.mem[14] !== 32'hE000_0000) begin nerr++; $display("FAIL wrap_entry14 got %h exp e0000000", dut.mem[14]); end
    nchk++; if (dut.tail[4] !== m_tail[4] || m_tail[4] !== 1'b1) begin
      nerr++; $display("FAIL wrap_tail_msb got %b exp 1", dut.tail[4]);
    end
    cycle(0, 32'h0, 0, 0);
    nchk++; if (dut.count !== 5'd0 || dut.head !== m_head) begin
      nerr++; $display("FAIL wrap_drain got count=%0d head=%0d exp 0/%0d", dut.count, dut.head, m_head);
    end
  endtask

  task automatic test_simultaneous();
    cycle(4, 32'h3000_0000, 0, 1);
    cycle(1, 32'h3000_0010, 0, 1);
    cycle(4, 32'h5000_0000, 0, 0);
    nchk++; if (dut.count !== 5'd5) begin nerr++; $display("FAIL simul_count got %0d exp 5", dut.count); end
    nchk++; if (dec_inst[0] !== 32'h3000_0010) begin nerr++; $display("FAIL simul_inst0 got %h exp 30000010", dec_inst[0]); end
    nchk++; if (dec_inst[1] !== 32'h5000_0000) begin nerr++; $display("FAIL simul_inst1 got %h exp 50000000", dec_inst[1]); end
    nchk++; if (dec_en !== 4'b1111) begin nerr++; $display("FAIL simul_dec_en got %b exp 1111", dec_en); end
  endtask

  task automatic test_flush();
    cycle(4, 32'h6000_0000, 0, 1);
    nchk++; if (dut.count !== 5'd9) begin nerr++; $display("FAIL preflush_count got %0d exp 9", dut.count); end
    cycle(2, 32'hBAD0_0000, 1, 0);
    nchk++; if (dut.count !== 5'd0) begin nerr++; $display("FAIL flush_count got %0d exp 0", dut.count); end
    nchk++; if (dec_en !== 4'b0000) begin nerr++; $display("FAIL flush_dec_en got %b exp 0000", dec_en); end
    nchk++; if (ib_stall !== 1'b0) begin nerr++; $display("FAIL flush_ib_stall got %b exp 0", ib_stall); end
    cycle(0, 32'h0, 0, 1);
    nchk++; if (dec_en !== 4'b0000) begin nerr++; $display("FAIL flush_after_dec_en got %b exp 0000", dec_en); end
    cycle(1, 32'h7777_0000, 0, 1);
    nchk++; if (dec_inst[0] !== 32'h7777_0000 || dec_en !== 4'b0001) begin
      nerr++; $display("FAIL flush_next_inst got %h/%b exp 77770000/0001", dec_inst[0], dec_en);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bit st;
    bit fl;
    bit exp_en;
    for (int k = 0; k < 80; k++) begin
      n  = $urandom_range(0, 4);
      st = ($urandom_range(0, 2) == 0);
      fl = ($urandom_range(0, 24) == 0);
      cycle(n, 32'h9000_0000 + 32'(k * 16), fl, st);
      nchk++;
      if (dut.count !== 5'(sb.size())) begin
        nerr++; $display("FAIL b2b_count cyc %0d got %0d exp %0d", k, dut.count, sb.size());
      end
      nchk++;
      if (ib_stall !== ((D - sb.size()) < IB)) begin
        nerr++; $display("FAIL b2b_ib_stall cyc %0d got %b exp %b", k, ib_stall, (D - sb.size()) < IB);
      end
      for (int i = 0; i < FW; i++) begin
        exp_en = (i < sb.size());
        nchk++;
        if (dec_en[i] !== exp_en) begin
          nerr++; $display("FAIL b2b_dec_en cyc %0d slot %0d got %b exp %b", k, i, dec_en[i], exp_en);
        end
        if (exp_en) begin
          nchk++;
          if (dec_inst[i] !== sb[i]) begin
            nerr++; $display("FAIL b2b_inst cyc %0d slot %0d got %h exp %h", k, i, dec_inst[i], sb[i]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill_stall();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
